// File: rtl/sat_delay_ascii_parser.sv
// sat_delay_ascii_parser: parses an ASCII decimal ms field into a 16.16 delay; build with SATDLY_RANGE_CHECK_EN to reject values outside MIN_MS..MAX_MS
module sat_delay_ascii_parser #(
  parameter int FRAC_DIGITS = 3,
  parameter int MIN_MS      = 100,
  parameter int MAX_MS      = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        field_start,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic [31:0] delay_value,
  output logic        delay_valid,
  output logic        parse_error,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, INT, FRAC, CONV} state_t;
  localparam logic [1:0] FD = 2'(FRAC_DIGITS);
  state_t      state;
  logic [15:0] int_acc;
  logic [9:0]  frac_acc;
  logic [1:0]  frac_cnt;
  logic        err, has_int;
  logic [3:0]  d;
  logic        is_digit, is_dot, is_term, range_bad, bad;
  logic [20:0] int_nxt;
  logic [9:0]  frac_nxt, f_ms;
  logic [26:0] prod;
  logic [16:0] frac_q;
  logic [15:0] frac16;
  assign d        = uart_rx_data[3:0];
  assign is_digit = uart_rx_data >= 8'h30 && uart_rx_data <= 8'h39;
  assign is_dot   = uart_rx_data == 8'h2e;
  assign is_term  = uart_rx_data == 8'h0d || uart_rx_data == 8'h0a;
  assign int_nxt  = ({5'b0, int_acc} << 3) + ({5'b0, int_acc} << 1) + {17'b0, d};
  assign frac_nxt = (frac_acc << 3) + (frac_acc << 1) + {6'b0, d};
  // Normalise the kept fractional digits to thousandths before scaling to 1/65536
  assign f_ms     = frac_cnt == 2'd0 ? 10'd0 :
                    frac_cnt == 2'd1 ? frac_acc * 10'd100 :
                    frac_cnt == 2'd2 ? frac_acc * 10'd10 : frac_acc;
  assign prod     = 27'(f_ms) * 27'd67109;
  assign frac_q   = 17'(prod >> 10);
  assign frac16   = frac_q[16] ? 16'hFFFF : frac_q[15:0];
`ifdef SATDLY_RANGE_CHECK_EN
  assign range_bad = int_acc < 16'(MIN_MS) || int_acc > 16'(MAX_MS) ||
                     (int_acc == 16'(MAX_MS) && f_ms != 10'd0);
`else
  assign range_bad = 1'b0;
`endif
  assign bad  = err || !has_int || range_bad;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      int_acc     <= '0;
      frac_acc    <= '0;
      frac_cnt    <= '0;
      err         <= 1'b0;
      has_int     <= 1'b0;
      delay_value <= '0;
      delay_valid <= 1'b0;
      parse_error <= 1'b0;
    end else begin
      delay_valid <= 1'b0;
      parse_error <= 1'b0;
      if (state == CONV) begin
        if (bad) parse_error <= 1'b1;
        else begin
          delay_value <= {int_acc, frac16};
          delay_valid <= 1'b1;
        end
      end
      if (field_start) begin
        state    <= INT;
        int_acc  <= '0;
        frac_acc <= '0;
        frac_cnt <= '0;
        err      <= 1'b0;
        has_int  <= 1'b0;
      end else if (state == CONV) begin
        state <= IDLE;
      end else if (state != IDLE && uart_rx_valid) begin
        if (is_term) state <= CONV;
        else if (err) state <= state;
        else if (state == INT) begin
          if (is_digit) begin
            has_int <= 1'b1;
            if (int_nxt > 21'd65535) err <= 1'b1;
            else int_acc <= int_nxt[15:0];
          end else if (is_dot) begin
            state <= FRAC;
            err   <= !has_int;
          end else err <= 1'b1;
        end else if (is_digit) begin
          if (frac_cnt < FD) begin
            frac_acc <= frac_nxt;
            frac_cnt <= frac_cnt + 2'd1;
          end
        end else err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sat_delay_ascii_parser.sv
// tb_sat_delay_ascii_parser: directed fields with a scoreboard of expected pulses, values and arrival cycles
module tb_sat_delay_ascii_parser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        field_start = 1'b0;
  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic [31:0] delay_value;
  logic        delay_valid, parse_error, busy;

`ifdef SATDLY_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    bit          e;
    logic [31:0] v;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          p0;
  bit          prev_pulse = 1'b0;
  logic [31:0] last_ok = 32'h0;

  sat_delay_ascii_parser dut (
    .clk(clk), .rst_n(rst_n), .field_start(field_start),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .delay_value(delay_value), .delay_valid(delay_valid),
    .parse_error(parse_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (delay_valid || parse_error)) begin
      pulses++;
      chk("exclusive", {31'b0, delay_valid & parse_error}, 32'h0);
      chk("one_cycle", {31'b0, prev_pulse}, 32'h0);
      if (q.size() == 0) chk("unexpected_pulse", 32'h1, 32'h0);
      else begin
        cur = q.pop_front();
        chk("kind", {31'b0, parse_error}, {31'b0, cur.e});
        chk("latency", cyc, cur.due);
        if (cur.e) chk("held", delay_value, last_ok);
        else begin
          chk("value", delay_value, cur.v);
          last_ok = cur.v;
        end
      end
    end
    prev_pulse = rst_n && (delay_valid || parse_error);
  end

  task automatic drive(bit fs, bit vld, logic [7:0] b);
    @(posedge clk);
    #1;
    field_start = fs;
    uart_rx_valid = vld;
    uart_rx_data = b;
  endtask

  task automatic send(string s, bit e, logic [31:0] v);
    exp_t t;
    for (int i = 0; i < s.len(); i++) begin
      drive(1'b0, 1'b1, s[i]);
      if (s[i] == 8'h0d || s[i] == 8'h0a) begin
        t.e = e;
        t.v = v;
        t.due = cyc + 2;
        q.push_back(t);
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    chk("drain", q.size(), 32'h0);
    @(negedge clk);
  endtask

  task automatic field(string s, bit e, logic [31:0] v);
    drive(1'b1, 1'b0, 8'h00);
    send(s, e, v);
    drive(1'b0, 1'b0, 8'h00);
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_value", delay_value, 32'h0);
    chk("rst_valid", {31'b0, delay_valid}, 32'h0);
    chk("rst_error", {31'b0, parse_error}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);

    field("120.5\015", 1'b0, 32'h0078_8000);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    field("119.9999\012", 1'b0, 32'h0077_FFBE);
    field("120.5\015", 1'b0, 32'h0078_8000);
    field("12a.0\015", 1'b1, 32'h0);
    chk("held_after_err", delay_value, 32'h0078_8000);
    field("70000\015", 1'b1, 32'h0);
    field("65536\015", 1'b1, 32'h0);
    field("\015", 1'b1, 32'h0);
    field(".5\015", 1'b1, 32'h0);
    field("1..5\015", 1'b1, 32'h0);
    field(" 5\015", 1'b1, 32'h0);
    field("-5\015", 1'b1, 32'h0);
    field("120.\015", 1'b0, 32'h0078_0000);
    field("007.250\015", RC, 32'h0007_4000);
    field("65535.999\015", RC, 32'hFFFF_FFBE);
    field("99\015", RC, 32'h0063_0000);
    field("100\015", 1'b0, 32'h0064_0000);
    field("150\015", 1'b0, 32'h0096_0000);
    field("150.001\015", RC, 32'h0096_0041);

    // field_start landing in the CONV cycle keeps the parser in INT
    drive(1'b1, 1'b0, 8'h00);
    send("100\015", 1'b0, 32'h0064_0000);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    chk("busy_after_conv_fs", {31'b0, busy}, 32'h1);
    send("101\015", 1'b0, 32'h0065_0000);
    drive(1'b0, 1'b0, 8'h00);
    drain();

    drive(1'b1, 1'b1, 8'h35);
    send("7\015", RC, 32'h0007_0000);
    drive(1'b0, 1'b0, 8'h00);
    drain();

    p0 = pulses;
    drive(1'b1, 1'b0, 8'h00);
    send("12", 1'b0, 32'h0);
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    last_ok = 32'h0;
    drive(1'b0, 1'b1, 8'h30);
    drive(1'b0, 1'b1, 8'h0d);
    drive(1'b0, 1'b0, 8'h00);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_pulses", pulses, p0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_value", delay_value, 32'h0);

    field("120.5\015", 1'b0, 32'h0078_8000);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
